// File: rtl/uart_rx_module.sv
// uart_rx_module: 8N1 UART receiver, LSB first, with start-bit validation at mid-bit
// and centre sampling of the data and stop bits.
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      asynchronous reset, active-high
//   i_rx_serial  asynchronous serial line, idle high
//   o_rx_active  high while a frame is in START/DATA/STOP
//   o_rx_valid   one-cycle pulse, o_rx_byte holds a new good byte
//   o_rx_byte    last good byte, held until the next good frame
//   o_frame_err  one-cycle pulse, stop bit sampled low
module uart_rx_module #(
    parameter int BIT_CLK_PER = 868
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx_serial,
    output logic       o_rx_active,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_byte,
    output logic       o_frame_err
);
    localparam int CW = $clog2(BIT_CLK_PER);
    localparam logic [CW-1:0] HALF_M1 = CW'(BIT_CLK_PER / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(BIT_CLK_PER - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK_WAIT} state_t;
    state_t        state, state_n;
    logic          rx_meta, rx_s;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift_reg, shift_n, byte_n;
    logic          valid_n, err_n;
    // Synchroniser presets to the idle level so reset release never looks like a start edge.
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift_reg   <= '0;
            o_rx_byte   <= '0;
            o_rx_valid  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            rx_meta     <= i_rx_serial;
            rx_s        <= rx_meta;
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            shift_reg   <= shift_n;
            o_rx_byte   <= byte_n;
            o_rx_valid  <= valid_n;
            o_frame_err <= err_n;
        end
    // Stop bit is sampled at its centre, so the return to IDLE leaves half a bit
    // to catch a back-to-back start edge.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift_reg;
        byte_n  = o_rx_byte;
        valid_n = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (!rx_s) state_n = START;
            end
            START:
                if (cnt < HALF_M1) cnt_n = cnt + 1'b1;
                else begin
                    cnt_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            DATA:
                if (cnt < BIT_M1) cnt_n = cnt + 1'b1;
                else begin
                    cnt_n        = '0;
                    shift_n[idx] = rx_s;
                    idx_n        = idx + 1'b1;
                    if (idx == 3'd7) state_n = STOP;
                end
            STOP:
                if (cnt < BIT_M1) cnt_n = cnt + 1'b1;
                else begin
                    cnt_n   = '0;
                    state_n = rx_s ? IDLE : BRK_WAIT;
                    valid_n = rx_s;
                    err_n   = !rx_s;
                    byte_n  = rx_s ? shift_reg : o_rx_byte;
                end
            BRK_WAIT:
                if (rx_s) state_n = IDLE;
            default:
                state_n = IDLE;
        endcase
    end
    assign o_rx_active = (state == START) || (state == DATA) || (state == STOP);
endmodule
